// File: rtl/regfile_port_arbiter_pkg.sv
// Shared constants for the register-file port arbiter: default widths,
// the hardwired-zero register address and the FSM state encodings.
package regfile_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;

  localparam logic [2:0] REG_ZERO = 3'b000;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: the first asserted request at or after ptr (wrapping)
// wins; gnt is one-hot and gnt_idx is its index. No grant when en is low.
module rr_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one register file (1 write, 2 registered read ports) between NREQ
// requesters, one transaction at a time, granted round-robin.
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_aa,
  input  logic [NREQ*ADDR_W-1:0] req_ba,
  input  logic [NREQ*ADDR_W-1:0] req_da,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_a,
  output logic [DATA_W-1:0]      rsp_b,
  output logic [ADDR_W-1:0]      rf_aa,
  output logic [ADDR_W-1:0]      rf_ba,
  output logic [ADDR_W-1:0]      rf_da,
  output logic [DATA_W-1:0]      rf_data_in,
  output logic                   rf_wr,
  input  logic [DATA_W-1:0]      rf_data_a,
  input  logic [DATA_W-1:0]      rf_data_b,
  output logic [1:0]             dbg_state
);

  localparam int IW = idx_w(NREQ);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     start_q, start_d;
  logic [IW-1:0]     id_q, id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] aa_q, aa_d, ba_q, ba_d, da_q, da_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;

  // Grants are suppressed while rst is high so nothing is accepted into a reset.
  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .req     (req_valid),
    .ptr     (start_q),
    .en      ((state_q == ST_IDLE) && !rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    id_d       = id_q;
    we_d       = we_q;
    aa_d       = aa_q;
    ba_d       = ba_q;
    da_d       = da_q;
    wdata_d    = wdata_q;
    rsp_a      = rsp_a_q;
    rsp_b      = rsp_b_q;
    rsp_valid  = '0;
    rf_aa      = '0;
    rf_ba      = '0;
    rf_da      = '0;
    rf_data_in = '0;
    rf_wr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
              we_d    = req_we[i];
              aa_d    = req_aa[i*ADDR_W +: ADDR_W];
              ba_d    = req_ba[i*ADDR_W +: ADDR_W];
              da_d    = req_da[i*ADDR_W +: ADDR_W];
              wdata_d = req_wdata[i*DATA_W +: DATA_W];
            end
          end
          id_d    = gnt_idx;
          start_d = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          rf_da      = da_q;
          rf_data_in = wdata_q;
          rf_wr      = (da_q != ZERO_A) && !rst;
          state_d    = ST_IDLE;
        end else begin
          rf_aa   = aa_q;
          rf_ba   = ba_q;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // The register file leaves its outputs stale on R0, so zero is forced here.
        if (!rst) begin
          rsp_valid[id_q] = 1'b1;
          rsp_a           = (aa_q == ZERO_A) ? '0 : rf_data_a;
          rsp_b           = (ba_q == ZERO_A) ? '0 : rf_data_b;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rsp_a_d = rsp_a;
    rsp_b_d = rsp_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      start_q <= '0;
      id_q    <= '0;
      we_q    <= 1'b0;
      aa_q    <= '0;
      ba_q    <= '0;
      da_q    <= '0;
      wdata_q <= '0;
      rsp_a_q <= '0;
      rsp_b_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      id_q    <= id_d;
      we_q    <= we_d;
      aa_q    <= aa_d;
      ba_q    <= ba_d;
      da_q    <= da_d;
      wdata_q <= wdata_d;
      rsp_a_q <= rsp_a_d;
      rsp_b_q <= rsp_b_d;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: register-file environment, directed steps,
// randomized traffic, and a transaction-level reference model.
module tb_regfile_port_arbiter;

  localparam int NREQ   = 2;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]        req_valid = '0, req_we = '0;
  logic [NREQ*ADDR_W-1:0] req_aa = '0, req_ba = '0, req_da = '0;
  logic [NREQ*DATA_W-1:0] req_wdata = '0;
  logic [NREQ-1:0]        req_ready, rsp_valid;
  logic [DATA_W-1:0]      rsp_a, rsp_b, rf_data_in;
  logic [ADDR_W-1:0]      rf_aa, rf_ba, rf_da;
  logic                   rf_wr;
  logic [DATA_W-1:0]      rf_data_a, rf_data_b;
  logic [1:0]             dbg_state;

  regfile_port_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_aa(req_aa), .req_ba(req_ba), .req_da(req_da), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_a(rsp_a), .rsp_b(rsp_b),
    .rf_aa(rf_aa), .rf_ba(rf_ba), .rf_da(rf_da), .rf_data_in(rf_data_in),
    .rf_wr(rf_wr), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .dbg_state(dbg_state)
  );

  // register file: registered read when not writing, outputs stale on R0
  logic [DATA_W-1:0] rf_mem [8];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
      rf_data_a <= '0;
      rf_data_b <= '0;
    end else if (rf_wr) begin
      rf_mem[rf_da] <= rf_data_in;
    end else begin
      if (rf_aa != 0) rf_data_a <= rf_mem[rf_aa];
      if (rf_ba != 0) rf_data_b <= rf_mem[rf_ba];
    end
  end

  // reference model state
  logic [DATA_W-1:0] ref_mem [8];
  int cyc = 0, idle_at = 0, wr_at = -1, rd_at = -1, rsp_at = -1, ref_start = 0;
  int exp_id = 0;
  logic [ADDR_W-1:0] exp_da, exp_aa, exp_ba;
  logic [DATA_W-1:0] exp_wd, exp_a, exp_b;
  logic [DATA_W-1:0] hold_a = '0, hold_b = '0;
  logic [NREQ-1:0]   acc_mask = '0;
  int grant_log[$];
  int wr_da_log[$];
  int rsp_cnt = 0, wr_seen = 0, rdy_seen = 0, last_acc_cyc = 0, last_rsp_cyc = 0;
  logic [NREQ-1:0]   last_rsp_valid = '0;
  logic [DATA_W-1:0] last_a = '0, last_b = '0;
  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  // one clock: check at negedge, advance model, step past posedge
  task automatic tick();
    logic in_rst;
    logic [NREQ-1:0] exp_rdy, exp_rsp;
    logic [ADDR_W-1:0] a, b, d;
    logic [DATA_W-1:0] w;
    int p, id;
    @(negedge clk);
    in_rst = rst;
    exp_rdy = '0;
    if (!in_rst && cyc >= idle_at) begin
      p = rr_pick(req_valid, ref_start);
      if (p >= 0) exp_rdy[p] = 1'b1;
    end
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rf_wr", 32'(rf_wr), 32'(!in_rst && cyc == wr_at));
    if (rf_wr) wr_seen++;
    if (req_ready != 0) rdy_seen++;
    if (!in_rst && cyc == wr_at) begin
      check("rf_da", 32'(rf_da), 32'(exp_da));
      check("rf_data_in", 32'(rf_data_in), 32'(exp_wd));
      wr_da_log.push_back(int'(rf_da));
    end
    if (!in_rst && cyc == rd_at) begin
      check("rf_aa", 32'(rf_aa), 32'(exp_aa));
      check("rf_ba", 32'(rf_ba), 32'(exp_ba));
    end
    exp_rsp = '0;
    if (!in_rst && cyc == rsp_at) exp_rsp[exp_id] = 1'b1;
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (exp_rsp != 0) begin
      hold_a = exp_a;
      hold_b = exp_b;
    end
    if (!in_rst) begin
      check("rsp_a", 32'(rsp_a), 32'(hold_a));
      check("rsp_b", 32'(rsp_b), 32'(hold_b));
    end
    if (rsp_valid != 0) begin
      rsp_cnt++;
      last_rsp_valid = rsp_valid;
      last_a = rsp_a;
      last_b = rsp_b;
      last_rsp_cyc = cyc;
    end
    acc_mask = req_valid & req_ready;
    if (in_rst) begin
      acc_mask = '0;
      idle_at = cyc + 1; wr_at = -1; rd_at = -1; rsp_at = -1; ref_start = 0;
      for (int i = 0; i < 8; i++) ref_mem[i] = '0;
      hold_a = '0; hold_b = '0;
    end else if (acc_mask != 0) begin
      id = acc_mask[0] ? 0 : 1;
      grant_log.push_back(id);
      last_acc_cyc = cyc;
      ref_start = (id + 1) % NREQ;
      a = req_aa[id*ADDR_W +: ADDR_W];
      b = req_ba[id*ADDR_W +: ADDR_W];
      d = req_da[id*ADDR_W +: ADDR_W];
      w = req_wdata[id*DATA_W +: DATA_W];
      if (req_we[id]) begin
        idle_at = cyc + 2;
        if (d != 0) begin
          wr_at = cyc + 1; exp_da = d; exp_wd = w; ref_mem[d] = w;
        end
      end else begin
        idle_at = cyc + 3; rd_at = cyc + 1; rsp_at = cyc + 2; exp_id = id;
        exp_aa = a; exp_ba = b;
        exp_a = (a == 0) ? '0 : ref_mem[a];
        exp_b = (b == 0) ? '0 : ref_mem[b];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // driver tasks
  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [ADDR_W-1:0] aa, input logic [ADDR_W-1:0] ba,
                         input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] wd);
    req_valid[i] = v;
    req_we[i]    = we;
    req_aa[i*ADDR_W +: ADDR_W]    = aa;
    req_ba[i*ADDR_W +: ADDR_W]    = ba;
    req_da[i*ADDR_W +: ADDR_W]    = da;
    req_wdata[i*DATA_W +: DATA_W] = wd;
  endtask

  task automatic do_txn(input int i, input logic we, input logic [ADDR_W-1:0] aa,
                        input logic [ADDR_W-1:0] ba, input logic [ADDR_W-1:0] da,
                        input logic [DATA_W-1:0] wd);
    logic got;
    got = 1'b0;
    set_req(i, 1'b1, we, aa, ba, da, wd);
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      got = acc_mask[i];
    end
    check("accept_in_time", 32'(got), 32'd1);
    req_valid[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_reset();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n0, g0;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;

    // 1: reset then idle
    tick(); tick();
    rst = 1'b0;
    check("reset_rf_aa", 32'(rf_aa), 32'd0);
    check("reset_rf_ba", 32'(rf_ba), 32'd0);
    check("reset_rf_da", 32'(rf_da), 32'd0);
    check("reset_rf_data_in", 32'(rf_data_in), 32'd0);
    check("reset_rf_wr", 32'(rf_wr), 32'd0);
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_a", 32'(rsp_a), 32'd0);
    check("reset_rsp_b", 32'(rsp_b), 32'd0);
    idle(10);
    check("idle_no_ready", 32'(rdy_seen), 32'd0);
    check("idle_no_wr", 32'(wr_seen), 32'd0);

    // 2: write R3=A5, read aa=3 ba=0
    do_txn(0, 1'b1, 3'd0, 3'd0, 3'd3, 8'hA5);
    idle(2);
    do_txn(0, 1'b0, 3'd3, 3'd0, 3'd0, 8'h00);
    idle(2);
    check("t2_rsp_valid", 32'(last_rsp_valid), 32'h1);
    check("t2_rsp_a", 32'(last_a), 32'hA5);
    check("t2_rsp_b", 32'(last_b), 32'h00);
    check("t2_latency", 32'(last_rsp_cyc - last_acc_cyc), 32'd2);

    // 3: both valid writes, alternating grants
    pulse_reset();
    grant_log.delete();
    wr_da_log.delete();
    set_req(0, 1'b1, 1'b1, 3'd0, 3'd0, 3'd1, 8'h11);
    set_req(1, 1'b1, 1'b1, 3'd0, 3'd0, 3'd2, 8'h22);
    for (int n = 0; n < 30 && grant_log.size() < 4; n++) tick();
    idle(2);
    check("t3_grant_count", 32'(grant_log.size()), 32'd4);
    check("t3_wr_count", 32'(wr_da_log.size()), 32'd4);
    if (grant_log.size() == 4 && wr_da_log.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("t3_grant", 32'(grant_log[k]), 32'(k % 2));
        check("t3_rf_da", 32'(wr_da_log[k]), 32'(k % 2 + 1));
      end
    end

    // 4: R0 write dropped, R0 read forced to zero despite stale outputs
    do_txn(0, 1'b0, 3'd1, 3'd2, 3'd0, 8'h00);
    idle(2);
    check("t4_pre_a", 32'(last_a), 32'h11);
    check("t4_pre_b", 32'(last_b), 32'h22);
    n0 = wr_seen;
    do_txn(0, 1'b1, 3'd0, 3'd0, 3'd0, 8'hFF);
    idle(2);
    check("t4_r0_no_wr", 32'(wr_seen - n0), 32'd0);
    do_txn(0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
    idle(2);
    check("t4_r0_rsp_a", 32'(last_a), 32'h00);
    check("t4_r0_rsp_b", 32'(last_b), 32'h00);

    // 5: reset during CAPTURE
    do_txn(1, 1'b1, 3'd0, 3'd0, 3'd3, 8'h77);
    idle(2);
    n0 = rsp_cnt;
    do_txn(1, 1'b0, 3'd3, 3'd3, 3'd0, 8'h00);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(2);
    check("t5_no_rsp", 32'(rsp_cnt - n0), 32'd0);
    g0 = grant_log.size();
    set_req(0, 1'b1, 1'b0, 3'd3, 3'd3, 3'd0, 8'h00);
    set_req(1, 1'b1, 1'b0, 3'd3, 3'd3, 3'd0, 8'h00);
    for (int n = 0; n < 10 && grant_log.size() == g0; n++) tick();
    req_valid = '0;
    idle(3);
    check("t5_rr_restart", 32'(grant_log.size() > g0 ? grant_log[g0] : -1), 32'd0);
    check("t5_cleared_a", 32'(last_a), 32'h00);
    check("t5_cleared_b", 32'(last_b), 32'h00);

    // 6: held req1 wins the next IDLE after req0's first transaction
    g0 = grant_log.size();
    set_req(0, 1'b1, 1'b0, 3'd1, 3'd2, 3'd0, 8'h00);
    for (int n = 0; n < 10 && grant_log.size() == g0; n++) tick();
    set_req(1, 1'b1, 1'b0, 3'd2, 3'd1, 3'd0, 8'h00);
    for (int n = 0; n < 20 && grant_log.size() < g0 + 3; n++) begin
      tick();
      if (acc_mask[1]) req_valid[1] = 1'b0;
    end
    idle(3);
    check("t6_grant_count", 32'(grant_log.size() - g0), 32'd3);
    if (grant_log.size() >= g0 + 3) begin
      check("t6_first", 32'(grant_log[g0]), 32'd0);
      check("t6_second", 32'(grant_log[g0+1]), 32'd1);
      check("t6_third", 32'(grant_log[g0+2]), 32'd0);
    end

    // randomized traffic with occasional withdrawals and resets
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || acc_mask[i]) begin
          set_req(i, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
